// File: rtl/wb_req_queue.sv
// Writeback request queue: FIFO between one long-latency unit (MUL or MEM) and the writeback arbiter.
// The oldest entry is offered as a request and retires only when the arbiter grants it.
package wb_req_pkg;
   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;
endpackage

module wb_req_queue
   import wb_req_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  wb_req_t          i_enq_req,
   output logic             o_enq_ready,
   output wb_req_t          o_wb_req,
   input  logic             i_grant,
   output logic [CNT_W-1:0] o_count
);

   // Handshake: an enqueue fires on i_enq_req.valid & o_enq_ready; a dequeue fires on
   // i_grant & o_wb_req.valid. Neither fires in a flush cycle. Ready depends on registered state only.
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   wb_req_t          mem_q [DEPTH];
   logic [CNT_W-2:0] wr_idx, rd_idx;
   logic [CNT_W-1:0] count;
   logic             enq_fire, deq_fire;

   assign wr_idx = wr_ptr_q[CNT_W-2:0];
   assign rd_idx = rd_ptr_q[CNT_W-2:0];
   assign count  = wr_ptr_q - rd_ptr_q;

   assign o_count     = count;
   assign o_enq_ready = (count != CNT_W'(DEPTH));

   assign enq_fire = i_enq_req.valid & o_enq_ready & ~i_flush;
   assign deq_fire = i_grant & o_wb_req.valid & ~i_flush;

   always_comb begin
      o_wb_req = '0;
      if (count != '0) begin
         o_wb_req       = mem_q[rd_idx];
         o_wb_req.valid = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (enq_fire) wr_ptr_d = wr_ptr_q + CNT_W'(1);
         if (deq_fire) rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Payload storage carries no reset; the pointers alone decide what is visible.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && enq_fire) mem_q[wr_idx] <= i_enq_req;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         assert (count <= CNT_W'(DEPTH))
            else $error("wb_req_queue: occupancy %0d exceeds depth", count);
         assert (!(i_enq_req.valid && !o_enq_ready && !i_flush))
            else $warning("wb_req_queue: enqueue while not ready, request dropped");
         assert (!(i_grant && !o_wb_req.valid && !i_flush))
            else $warning("wb_req_queue: grant while empty, ignored");
      end
   end

endmodule

// File: tb/tb_wb_req_queue.sv
// Directed bench for wb_req_queue: vector table for reset/fill/drain/flush, then a wrap sequence
// checked against an expected queue.
module tb_wb_req_queue;
   import wb_req_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int W     = $bits(wb_req_t);

   logic             clk;
   logic             rst_n;
   logic             flush;
   wb_req_t          enq_req;
   logic             enq_ready;
   wb_req_t          wb_req;
   logic             grant;
   logic [CNT_W-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q [$];

   wb_req_queue #(.DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_flush     (flush),
      .i_enq_req   (enq_req),
      .o_enq_ready (enq_ready),
      .o_wb_req    (wb_req),
      .i_grant     (grant),
      .o_count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             rst_n;
      logic             flush;
      wb_req_t          enq;
      logic             grant;
      logic [CNT_W-1:0] exp_count;
      logic             exp_ready;
      wb_req_t          exp_req;
   } vec_t;

   vec_t vecs [$];

   function automatic wb_req_t item(input int k);
      wb_req_t r;
      r.valid = 1'b1;
      r.rd    = 5'(k);
      r.data  = 32'hA000_0000 | 32'(k * 32'h0101);
      return r;
   endfunction

   function automatic vec_t mk(input logic rn, input logic fl, input int enq_k, input logic gr,
                               input int ec, input logic er, input int out_k);
      vec_t v;
      v.rst_n     = rn;
      v.flush     = fl;
      v.enq       = (enq_k > 0) ? item(enq_k) : '0;
      v.grant     = gr;
      v.exp_count = CNT_W'(ec);
      v.exp_ready = er;
      v.exp_req   = (out_k > 0) ? item(out_k) : '0;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rn, input logic fl, input wb_req_t e, input logic gr);
      rst_n   = rn;
      flush   = fl;
      enq_req = e;
      grant   = gr;
   endtask

   initial begin
      drive(1'b0, 1'b0, '0, 1'b0);
      // Items: A=1 .. H=8. Args: rst_n, flush, enq item, grant, exp count, exp ready, exp head.
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));   // reset held with enqueue attempt
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 1, 1, 1));   // A into empty queue
      vecs.push_back(mk(1, 0, 2, 0, 2, 1, 1));
      vecs.push_back(mk(1, 0, 3, 0, 3, 1, 1));
      vecs.push_back(mk(1, 0, 4, 0, 4, 0, 1));   // full
      vecs.push_back(mk(1, 0, 0, 1, 3, 1, 2));   // drain in order
      vecs.push_back(mk(1, 0, 0, 1, 2, 1, 3));
      vecs.push_back(mk(1, 0, 0, 1, 1, 1, 4));
      vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 1, 1, 1));   // count=1 with A
      vecs.push_back(mk(1, 0, 2, 1, 1, 1, 2));   // enq B + pop A
      vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));   // stray grant on empty
      vecs.push_back(mk(1, 0, 5, 0, 1, 1, 5));
      vecs.push_back(mk(1, 0, 6, 0, 2, 1, 5));
      vecs.push_back(mk(1, 0, 7, 0, 3, 1, 5));
      vecs.push_back(mk(1, 1, 8, 1, 0, 1, 0));   // flush beats enq H and grant
      vecs.push_back(mk(1, 0, 8, 0, 1, 1, 8));   // H lands at slot 0, no stale E
      vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 1, 1, 1));
      vecs.push_back(mk(1, 0, 2, 0, 2, 1, 1));
      vecs.push_back(mk(0, 0, 3, 1, 0, 1, 0));   // reset mid-operation
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].flush, vecs[i].enq, vecs[i].grant);
         tick();
         check($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].exp_count));
         check($sformatf("vec%0d ready", i), 64'(enq_ready), 64'(vecs[i].exp_ready));
         check($sformatf("vec%0d head", i), 64'(wb_req), 64'(vecs[i].exp_req));
      end

      // Wrap: 10 items with mixed enq/grant/gap cycles, pointers pass the end more than once.
      drive(1'b1, 1'b0, '0, 1'b0);
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
         logic    do_grant;
         wb_req_t it;
         it = item(16 + i);
         it.data = 32'hC0DE_0000 + 32'(i);
         do_grant = (exp_q.size() > 0) && (i % 3 != 0);
         if (do_grant) check($sformatf("wrap%0d head", i), 64'(wb_req), 64'(exp_q[0]));
         drive(1'b1, 1'b0, it, do_grant);
         tick();
         if (do_grant) void'(exp_q.pop_front());
         exp_q.push_back(it);
         check($sformatf("wrap%0d count", i), 64'(count), 64'(exp_q.size()));
         drive(1'b1, 1'b0, '0, 1'b0);
         for (int g = 0; g < (i % 3); g++) tick();
      end
      for (int k = 0; k < 2 * DEPTH && exp_q.size() > 0; k++) begin
         check($sformatf("drain%0d head", k), 64'(wb_req), 64'(exp_q[0]));
         drive(1'b1, 1'b0, '0, 1'b1);
         tick();
         void'(exp_q.pop_front());
         check($sformatf("drain%0d count", k), 64'(count), 64'(exp_q.size()));
      end
      check("drain complete", 64'(exp_q.size()), 64'd0);
      drive(1'b1, 1'b0, '0, 1'b0);
      tick();
      check("final valid", 64'(wb_req.valid), 64'd0);
      check("final ready", 64'(enq_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
